// File: rtl/devkit_gpio.sv
// Board I/O peripheral: LED output register, debounced pushbuttons with sticky
// press flags and a maskable level interrupt, on a one-cycle-latency memory bus.
module devkit_gpio #(
  parameter int          N_LED           = 5,
  parameter int          N_PB            = 4,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter bit          PB_ACTIVE_LOW   = 1'b1,
  parameter logic [31:0] LED_RESET       = 32'h0,
  parameter logic [31:0] ADDR_MASK       = 32'hFFFFFFF0,
  parameter logic [31:0] ADDR_BASE       = 32'hFFFE0000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      ADDR,
  input  logic             CS,
  input  logic             WR,
  input  logic [3:0]       MASK,
  input  logic [31:0]      DIN,
  output logic [31:0]      DOUT,
  output logic [N_LED-1:0] LED,
  input  logic [N_PB-1:0]  PB,
  output logic             IRQ
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]    LED_IMPL = 32'hFFFF_FFFF >> (32 - N_LED);
  localparam logic [31:0]    PB_IMPL  = 32'hFFFF_FFFF >> (32 - N_PB);

  logic              hit;
  logic              wr_en;
  logic [1:0]        reg_sel;
  logic [31:0]       byte_mask;
  logic [31:0]       wr_bits;

  logic [N_PB-1:0]   pb_in;
  logic [N_PB-1:0]   pb_sync0;
  logic [N_PB-1:0]   pb_sync1;
  logic [N_PB-1:0]   pb_state;
  logic [N_PB-1:0]   pb_press;
  logic [CW-1:0]     db_cnt [N_PB];

  // Registers are kept 32 bits wide; unimplemented bits are held at zero.
  logic [31:0]       led_reg;
  logic [31:0]       edge_reg;
  logic [31:0]       irq_en_reg;
  logic [31:0]       led_next;
  logic [31:0]       edge_next;
  logic [31:0]       irq_en_next;
  logic [31:0]       edge_clr;
  logic [31:0]       rdata;

  assign hit       = (ADDR & ADDR_MASK) == ADDR_BASE;
  assign wr_en     = CS & WR & hit;
  assign reg_sel   = ADDR[3:2];
  assign byte_mask = {{8{MASK[3]}}, {8{MASK[2]}}, {8{MASK[1]}}, {8{MASK[0]}}};
  assign wr_bits   = DIN & byte_mask;
  assign pb_in     = PB_ACTIVE_LOW ? ~PB : PB;
  assign LED       = led_reg[N_LED-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pb_sync0 <= '0;
      pb_sync1 <= '0;
    end else begin
      pb_sync0 <= pb_in;
      pb_sync1 <= pb_sync0;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pb_state <= '0;
      for (int i = 0; i < N_PB; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PB; i++) begin
        if (pb_sync1[i] == pb_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          pb_state[i] <= pb_sync1[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pb_press = '0;
    for (int i = 0; i < N_PB; i++) begin
      pb_press[i] = pb_sync1[i] & ~pb_state[i] & (db_cnt[i] == CNT_LAST);
    end
  end

  // A press in the same cycle as a W1C clear wins, so no event is lost.
  always_comb begin
    led_next    = led_reg;
    irq_en_next = irq_en_reg;
    edge_clr    = '0;
    if (wr_en) begin
      case (reg_sel)
        2'd0:    led_next    = ((led_reg & ~byte_mask) | wr_bits) & LED_IMPL;
        2'd2:    edge_clr    = wr_bits;
        2'd3:    irq_en_next = ((irq_en_reg & ~byte_mask) | wr_bits) & PB_IMPL;
        default: ;
      endcase
    end
    edge_next = ((edge_reg & ~edge_clr) | 32'(pb_press)) & PB_IMPL;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata = led_reg;
      2'd1:    rdata = 32'(pb_state);
      2'd2:    rdata = edge_reg;
      default: rdata = irq_en_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_reg    <= LED_RESET & LED_IMPL;
      edge_reg   <= '0;
      irq_en_reg <= '0;
      IRQ        <= 1'b0;
    end else begin
      led_reg    <= led_next;
      edge_reg   <= edge_next;
      irq_en_reg <= irq_en_next;
      IRQ        <= |(edge_reg & irq_en_reg);
    end
  end

  // Read data holds between accesses; a write or an address miss returns zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOUT <= '0;
    end else if (CS) begin
      DOUT <= (!WR && hit) ? rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_devkit_gpio.sv
// Directed bench for devkit_gpio: bus reads are scored through an expected-value
// queue drained by an independent monitor; LED/IRQ levels are checked directly.
module tb_devkit_gpio;

  localparam logic [31:0] BASE   = 32'hFFFE0000;
  localparam logic [31:0] A_LED  = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_EDGE = BASE + 32'h8;
  localparam logic [31:0] A_EN   = BASE + 32'hC;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] ADDR;
  logic        CS;
  logic        WR;
  logic [3:0]  MASK;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic [4:0]  LED;
  logic [3:0]  PB;
  logic        IRQ;

  always #5 CLK = ~CLK;

  devkit_gpio #(
    .N_LED(5),
    .N_PB(4),
    .DEBOUNCE_CYCLES(4),
    .PB_ACTIVE_LOW(1'b1),
    .LED_RESET(32'h15),
    .ADDR_MASK(32'hFFFFFFF0),
    .ADDR_BASE(BASE)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .ADDR(ADDR),
    .CS(CS),
    .WR(WR),
    .MASK(MASK),
    .DIN(DIN),
    .DOUT(DOUT),
    .LED(LED),
    .PB(PB),
    .IRQ(IRQ)
  );

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rd_pending;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rd_pending <= 1'b0;
    else        rd_pending <= CS & ~WR;
  end

  // Monitor: one read response is due on the cycle after every read strobe.
  always @(negedge CLK) begin
    if (rd_pending) begin : mon
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL read_unexpected: DOUT=%h, no expected value queued", DOUT);
      end else begin
        e = exp_q.pop_front();
        if (DOUT !== e.value) begin
          n_fail++;
          $display("[TB] FAIL %s: DOUT=%h expected %h", e.name, DOUT, e.value);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] din, input logic [3:0] mask,
                               input logic [31:0] exp, input string name);
    exp_t e;
    ADDR = addr;
    WR   = wr;
    DIN  = din;
    MASK = mask;
    CS   = 1'b1;
    if (!wr) begin
      e.name  = name;
      e.value = exp;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    CS = 1'b0;
    WR = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    CS    = 1'b0;
    WR    = 1'b0;
    ADDR  = '0;
    DIN   = '0;
    MASK  = '0;
    PB    = 4'hF;
    cycles(3);
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("reset_led", 32'(LED), 32'h15);
    checkOutput("reset_dout", DOUT, 32'h0);
    checkOutput("reset_irq", 32'(IRQ), 32'h0);
    applyStimulus(1'b0, A_STAT, 0, 4'hF, 32'h0, "reset_pb_state");
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h0, "reset_pb_edge");
    applyStimulus(1'b0, A_EN,   0, 4'hF, 32'h0, "reset_pb_irq_en");
    applyStimulus(1'b0, A_LED,  0, 4'hF, 32'h15, "reset_led_read");

    applyStimulus(1'b1, A_LED, 32'hFFFFFF0A, 4'b0001, 0, "");
    checkOutput("led_byte0_write", 32'(LED), 32'h0A);
    applyStimulus(1'b1, A_LED, 32'h0, 4'b0000, 0, "");
    checkOutput("led_no_mask_write", 32'(LED), 32'h0A);
    applyStimulus(1'b0, A_LED, 0, 4'hF, 32'h0000000A, "led_read");

    // Three-cycle glitch on PB[0] must be dropped.
    PB[0] = 1'b0;
    cycles(3);
    PB[0] = 1'b1;
    cycles(6);
    applyStimulus(1'b0, A_STAT, 0, 4'hF, 32'h0, "glitch_state");
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h0, "glitch_edge");

    // Held press: reads sampled on edges 1..7 after the pin change; state flips at edge 6.
    PB[0] = 1'b0;
    for (int k = 1; k <= 7; k++)
      applyStimulus(1'b0, A_STAT, 0, 4'hF, (k == 7) ? 32'h1 : 32'h0, $sformatf("debounce_state_e%0d", k));
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h1, "debounce_edge");

    applyStimulus(1'b1, A_EDGE, 32'h1, 4'b0001, 0, "");
    PB[0] = 1'b1;
    cycles(8);
    applyStimulus(1'b1, A_EN, 32'h1, 4'b0001, 0, "");
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h0, "release_no_edge");

    PB[0] = 1'b0;
    cycles(6);
    checkOutput("irq_same_cycle_as_edge", 32'(IRQ), 32'h0);
    cycles(1);
    checkOutput("irq_rise", 32'(IRQ), 32'h1);
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h1, "irq_edge_set");
    applyStimulus(1'b1, A_EDGE, 32'h1, 4'b0001, 0, "");
    checkOutput("irq_hold_after_clear", 32'(IRQ), 32'h1);
    cycles(1);
    checkOutput("irq_fall", 32'(IRQ), 32'h0);
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h0, "edge_cleared");

    PB[1] = 1'b0;
    cycles(8);
    checkOutput("irq_masked_pb1", 32'(IRQ), 32'h0);
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h2, "edge_pb1_masked");

    // W1C of PB_EDGE[2] lands on the edge where PB[2] is accepted.
    PB[2] = 1'b0;
    cycles(5);
    applyStimulus(1'b1, A_EDGE, 32'h4, 4'b0001, 0, "");
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h6, "set_clear_collision");
    applyStimulus(1'b1, A_EDGE, 32'h4, 4'b0001, 0, "");
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h2, "w1c_clear_pb2");
    applyStimulus(1'b1, A_EDGE, 32'h2, 4'b0000, 0, "");
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'h2, "w1c_byte_disabled");
    applyStimulus(1'b1, A_STAT, 32'h0, 4'hF, 0, "");
    applyStimulus(1'b0, A_STAT, 0, 4'hF, 32'h7, "state_write_ignored");
    applyStimulus(1'b0, A_EN, 0, 4'hF, 32'h1, "irq_en_read");
    applyStimulus(1'b0, 32'h00000004, 0, 4'hF, 32'h0, "addr_miss");
    applyStimulus(1'b0, A_STAT, 0, 4'hF, 32'h7, "state_before_reset");

    // Reset in the middle of the PB[3] debounce count.
    PB[3] = 1'b0;
    cycles(4);
    RST_N = 1'b0;
    #1;
    checkOutput("midreset_dout", DOUT, 32'h0);
    checkOutput("midreset_led", 32'(LED), 32'h15);
    checkOutput("midreset_irq", 32'(IRQ), 32'h0);
    cycles(2);
    RST_N = 1'b1;
    for (int k = 1; k <= 7; k++)
      applyStimulus(1'b0, A_STAT, 0, 4'hF, (k == 7) ? 32'hF : 32'h0, $sformatf("post_reset_state_e%0d", k));
    applyStimulus(1'b0, A_EDGE, 0, 4'hF, 32'hF, "post_reset_edge");
    applyStimulus(1'b0, A_EN, 0, 4'hF, 32'h0, "post_reset_irq_en");
    checkOutput("post_reset_irq", 32'(IRQ), 32'h0);

    cycles(2);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
